// File: rtl/imem_loader.sv
// Byte-stream program loader: frames of N 16-bit instructions plus an XOR checksum
// are written into the instruction memory while the processor is held in reset.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int BYTE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  in_valid,
    input  logic [BYTE_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [2*BYTE_W-1:0]   imem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_W:0]       inst_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        CHK,
        DONE,
        ERR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BYTE_W-1:0]     r_upper;
    logic [BYTE_W-1:0]     r_acc;
    logic [ADDR_W:0]       r_n;
    logic [ADDR_W:0]       r_count;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [2*BYTE_W-1:0]   r_wdata;
    logic                  r_cpu_reset;

    logic                  w_xfer;
    logic                  w_hdr_bad;
    logic                  w_last;

    // restart wins over a simultaneous byte, so the byte is never consumed
    assign w_xfer    = in_valid && in_ready && !restart;
    assign w_hdr_bad = (in_data == '0) || ({1'b0, in_data} > (BYTE_W + 1)'(DEPTH));
    assign w_last    = ((r_count + (ADDR_W + 1)'(1)) == r_n);

    assign in_ready   = (r_state == IDLE) || (r_state == HI) ||
                        (r_state == LO)   || (r_state == CHK);
    assign load_done  = (r_state == DONE);
    assign load_err   = (r_state == ERR);
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign inst_count = r_count;

    // NOTE: combinational block assigns its output a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        if (restart) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_xfer) w_next = w_hdr_bad ? ERR : HI;
                HI:      if (w_xfer) w_next = LO;
                LO:      if (w_xfer) w_next = w_last ? CHK : HI;
                CHK:     if (w_xfer) w_next = (in_data == r_acc) ? DONE : ERR;
                default: w_next = r_state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_upper     <= '0;
            r_acc       <= '0;
            r_n         <= '0;
            r_count     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_we        <= 1'b0;
            // Released only after a full cycle in DONE; re-asserted as soon as DONE is left
            r_cpu_reset <= !((r_state == DONE) && (w_next == DONE));
            if (restart) begin
                r_count <= '0;
            end else if (w_xfer) begin
                case (r_state)
                    IDLE: begin
                        r_n     <= in_data[ADDR_W:0];
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                    HI: begin
                        r_upper <= in_data;
                        r_acc   <= r_acc ^ in_data;
                    end
                    LO: begin
                        r_acc   <= r_acc ^ in_data;
                        r_we    <= 1'b1;
                        r_wdata <= {r_upper, in_data};
                        r_addr  <= r_count[ADDR_W-1:0];
                        r_count <= r_count + (ADDR_W + 1)'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames plus hand-written restart
// and async-reset sequences; memory writes are checked against a scoreboard queue.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        restart;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [5:0]  inst_count;

    imem_loader #(.ADDR_W(5), .BYTE_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err),
        .inst_count (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        bad;
        int          gmax;
        logic        exp_done;
        logic        exp_err;
        logic [5:0]  exp_count;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic        prev_we  = 1'b0;
    logic [15:0] frame_words[32];
    vec_t        vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every imem_we pulse must match the oldest expected write
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'b0, imem_we}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", {27'b0, imem_addr}, {27'b0, mon_e.addr});
                check("write_data", {16'b0, imem_wdata}, {16'b0, mon_e.data});
                check("write_count", {26'b0, inst_count}, {27'b0, mon_e.addr} + 32'd1);
            end
            if (prev_we) check("we_pulse_width", {31'b0, prev_we}, 32'd0);
        end
        prev_we = imem_we;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        check("in_ready_at_xfer", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic pick_gap(input int gmax, output int g);
        g = (gmax == 0) ? 0 : int'($urandom_range(0, gmax));
    endtask

    task automatic run_frame(input logic [7:0] hdr, input logic bad, input int gmax);
        logic [7:0] acc;
        int         g;
        send_byte(hdr, 0);
        if (hdr != 8'd0 && hdr <= 8'd32) begin
            acc = 8'h00;
            for (int i = 0; i < int'(hdr); i++) begin
                pick_gap(gmax, g);
                send_byte(frame_words[i][15:8], g);
                exp_q.push_back('{addr: 5'(i), data: frame_words[i]});
                pick_gap(gmax, g);
                send_byte(frame_words[i][7:0], g);
                acc = acc ^ frame_words[i][15:8] ^ frame_words[i][7:0];
            end
            pick_gap(gmax, g);
            send_byte(acc ^ {7'b0, bad}, g);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_restart(input logic v, input logic [7:0] d);
        @(negedge clk);
        restart  = 1'b1;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        check("restart_done", {31'b0, load_done}, 32'd0);
        check("restart_err", {31'b0, load_err}, 32'd0);
        check("restart_count", {26'b0, inst_count}, 32'd0);
        check("restart_ready", {31'b0, in_ready}, 32'd1);
        check("restart_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_imem_we"}, {31'b0, imem_we}, 32'd0);
        check({tag, "_imem_addr"}, {27'b0, imem_addr}, 32'd0);
        check({tag, "_imem_wdata"}, {16'b0, imem_wdata}, 32'd0);
        check({tag, "_cpu_reset"}, {31'b0, cpu_reset}, 32'd1);
        check({tag, "_load_done"}, {31'b0, load_done}, 32'd0);
        check({tag, "_load_err"}, {31'b0, load_err}, 32'd0);
        check({tag, "_inst_count"}, {26'b0, inst_count}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h02, 16'h1234, 16'hABCD, 1'b0, 0, 1'b1, 1'b0, 6'd2};
        vecs[1] = '{8'h02, 16'h1234, 16'hABCD, 1'b1, 0, 1'b0, 1'b1, 6'd2};
        vecs[2] = '{8'h00, 16'h0000, 16'h0000, 1'b0, 0, 1'b0, 1'b1, 6'd0};
        vecs[3] = '{8'h21, 16'h0000, 16'h0000, 1'b0, 0, 1'b0, 1'b1, 6'd0};
        vecs[4] = '{8'h20, 16'h5A5A, 16'hC3C3, 1'b0, 3, 1'b1, 1'b0, 6'd32};
        vecs[5] = '{8'h01, 16'h00FF, 16'h0000, 1'b1, 1, 1'b0, 1'b1, 6'd1};

        reset    = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("post_release");

        for (int v = 0; v < 6; v++) begin
            do_restart(1'b0, 8'h00);
            frame_words[0] = vecs[v].w0;
            frame_words[1] = vecs[v].w1;
            for (int i = 2; i < 32; i++) frame_words[i] = 16'($urandom);
            run_frame(vecs[v].hdr, vecs[v].bad, vecs[v].gmax);
            check($sformatf("v%0d_load_done", v), {31'b0, load_done}, {31'b0, vecs[v].exp_done});
            check($sformatf("v%0d_load_err", v), {31'b0, load_err}, {31'b0, vecs[v].exp_err});
            check($sformatf("v%0d_in_ready", v), {31'b0, in_ready}, 32'd0);
            check($sformatf("v%0d_cpu_reset_first", v), {31'b0, cpu_reset}, 32'd1);
            check($sformatf("v%0d_inst_count", v), {26'b0, inst_count}, {26'b0, vecs[v].exp_count});
            check($sformatf("v%0d_sb_drained", v), exp_q.size(), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_cpu_reset", v), {31'b0, cpu_reset}, {31'b0, !vecs[v].exp_done});
            // A byte offered while not ready must be ignored
            in_valid = 1'b1;
            in_data  = 8'h5A;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d_hold_done", v), {31'b0, load_done}, {31'b0, vecs[v].exp_done});
            check($sformatf("v%0d_hold_count", v), {26'b0, inst_count}, {26'b0, vecs[v].exp_count});
        end

        // restart together with a valid 4th byte, while a write is in flight
        do_restart(1'b0, 8'h00);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        exp_q.push_back('{addr: 5'd0, data: 16'h1122});
        send_byte(8'h22, 0);
        do_restart(1'b1, 8'h33);
        check("mid_restart_sb_drained", exp_q.size(), 32'd0);
        frame_words[0] = 16'h0007;
        run_frame(8'h01, 1'b0, 0);
        check("reload_done", {31'b0, load_done}, 32'd1);
        check("reload_count", {26'b0, inst_count}, 32'd1);
        check("reload_sb_drained", exp_q.size(), 32'd0);

        // async reset while in LO with the low byte being presented
        do_restart(1'b0, 8'h00);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hBB;
        #2 reset = 1'b0;
        #1 check_reset_values("async");
        @(negedge clk);
        check("async_no_we", {31'b0, imem_we}, 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_reset_values("after_async");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
